reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Board-level reset sequencer on the system clock, sitting directly upstream of the SoC in the FPGA top. It merges power-on, a debounced board button and a debug-module reset request into one reset event, and holds reset for a fixed time. It releases peripheral reset first and CPU reset a fixed number of cycles later. It records which source caused the last reset.

Parameters:
- DEBOUNCE_CYCLES, 255: consecutive stable cycles of the synced button level needed before the filtered level changes. Must be ≥1.
- HOLD_CYCLES, 16: cycles both resets stay low after the last active trigger. Must be ≥1.
- STAGGER_CYCLES, 8: cycles between rst_n_periph release and rst_n_cpu release. 0 means both release on the same cycle.
- WDOG_W, 20: watchdog counter width. Used only with the optional feature.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset (power-on). Fixed decision: one clock; reset is asynchronous and active-low.
- btn_n, input, 1: board reset button, active-low, asynchronous and bouncy.
- ndmreset_req, input, 1: debug-module reset request, synchronous to clk, level-sensitive.
- wdog_kick, input, 1: watchdog service pulse, synchronous.
- rst_n_periph, output, 1: peripheral/bus reset, active-low, registered.
- rst_n_cpu, output, 1: CPU reset, active-low, registered.
- in_reset, output, 1: high while either output reset is asserted.
- reset_cause, output, 2: cause of the last reset. 00 = POR, 01 = button, 10 = debug, 11 = watchdog.

Behaviour:
- Reset values while rst_n is low:
  - rst_n_periph = 0, rst_n_cpu = 0, in_reset = 1, reset_cause = 00.
  - State = ASSERT, all counters = 0.
  - Debounce filtered level = 1 (released).
- btn_n synchronisation:
  - Two-flop synchroniser, both flops reset to 1.
  - Debounce counter clears whenever the synced level equals the filtered level.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES the filtered level takes the synced value and the counter clears.
  - btn_trig = (filtered level == 0).
- Trigger:
  - trig = btn_trig | ndmreset_req | wdog_trig.
  - Level-sensitive: a held trigger keeps the block in ASSERT with the hold counter at 0.
- State machine (count is $clog2-sized, saturating not required):
  - ASSERT: both resets low. If trig, count cleared. Otherwise count increments; when count == HOLD_CYCLES-1, go to RELEASE_PERIPH, or to RUN if STAGGER_CYCLES == 0.
  - RELEASE_PERIPH: rst_n_periph = 1, rst_n_cpu = 0. Count increments from 0; at STAGGER_CYCLES-1 go to RUN.
  - RUN: both resets high.
  - trig in any state → ASSERT next cycle with count = 0. Outputs drop on the same edge, so there is one cycle of latency from trigger to reset low.
- Timing after rst_n deasserts with no trigger:
  - rst_n_periph rises after exactly HOLD_CYCLES clk edges.
  - rst_n_cpu rises after exactly HOLD_CYCLES + STAGGER_CYCLES edges.
- reset_cause update:
  - Updated on every cycle trig is high.
  - Priority when sources coincide: button (01) > watchdog (11) > debug (10).
  - Holds its value otherwise; survives the sequenced reset, cleared only by rst_n.
- A trigger during ASSERT or RELEASE_PERIPH restarts the full sequence from the hold phase.
- All outputs come directly from flops, with no combinational decode, so they are glitch-free.

Optional Feature:
- Macro: RESET_SEQUENCER_WDOG_EN.
- Defined:
  - WDOG_W-bit counter counts only in RUN and clears in other states or on wdog_kick.
  - wdog_trig is a one-cycle pulse when the counter reaches all-ones. The counter then clears, and the block returns to ASSERT.
  - If wdog_kick and expiry fall on the same cycle, the kick wins and there is no trigger.
- Undefined:
  - wdog_trig is tied 0 and no counter exists.
  - wdog_kick is ignored; the port stays present.
  - Cause 11 is never produced.

Decomposition:
- Shared package reset_seq_pkg holds:
  - cause encodings: CAUSE_POR, CAUSE_BTN, CAUSE_DBG, CAUSE_WDOG;
  - state encodings: ST_ASSERT, ST_RELEASE_PERIPH, ST_RUN.
- One natural sub-module, reset_seq_debounce, containing the synchroniser and debounce counter.

Test Plan:
- POR sequencing: release rst_n, defaults, no triggers → rst_n_periph rises at edge 16, rst_n_cpu at edge 24, in_reset falls at edge 24, reset_cause = 00.
- Button bounce: in RUN, btn_n low for 100 cycles then high, with DEBOUNCE_CYCLES = 255 → no reset. Then btn_n low for 300 cycles → both resets drop one cycle after the filtered level falls. After release, the filtered level returns high after 255 stable cycles, periph releases 16 cycles later and cpu 8 after that, reset_cause = 01.
- Debug request: ndmreset_req high for 5 cycles in RUN → resets low for 5 + 16 cycles before periph release, reset_cause = 10.
- Simultaneous sources: filtered button low and ndmreset_req on the same cycle → reset_cause = 01.
- Mid-sequence retrigger: ndmreset_req 1-cycle pulse during RELEASE_PERIPH at stagger count 4 → rst_n_periph drops next cycle, full 16 + 8 sequence repeats.
- Watchdog (macro on, WDOG_W = 4): no kicks in RUN → reset after 16 RUN cycles, reset_cause = 11. With kicks every 10 cycles → never resets.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state/cause encodings and counter sizing for the reset sequencer
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT         = 2'b00,
    ST_RELEASE_PERIPH = 2'b01,
    ST_RUN            = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_DBG  = 2'b10,
    CAUSE_WDOG = 2'b11
  } cause_e;

  // Bits needed to hold a count of 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - reset trigger inputs and sequenced reset outputs of the reset sequencer
interface reset_sequencer_if;
  logic       btn_n;
  logic       ndmreset_req;
  logic       wdog_kick;
  logic       rst_n_periph;
  logic       rst_n_cpu;
  logic       in_reset;
  logic [1:0] reset_cause;

  modport master (
    input  btn_n, ndmreset_req, wdog_kick,
    output rst_n_periph, rst_n_cpu, in_reset, reset_cause
  );

  modport slave (
    output btn_n, ndmreset_req, wdog_kick,
    input  rst_n_periph, rst_n_cpu, in_reset, reset_cause
  );
endinterface

// File: rtl/reset_seq_debounce.sv
// rtl/reset_seq_debounce.sv - two-flop synchroniser and stable-level debounce for the board reset button
module reset_seq_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic btn_trig
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Filtered level only follows the synced level after an unbroken run of mismatching cycles.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and filter state; everything idles at the released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_trig = ~filt_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - merges reset sources, holds and staggers periph/cpu release (watchdog: RESET_SEQUENCER_WDOG_EN)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 255,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGGER_CYCLES  = 8,
  parameter int WDOG_W          = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  reset_sequencer_if.master  bus
);

  localparam int CNT_W = cnt_width((HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES);

  logic btn_trig;
  logic wdog_trig;
  logic trig;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             periph_q, periph_d;
  logic             cpu_q, cpu_d;
  logic             in_reset_q, in_reset_d;
  cause_e           cause_q, cause_d;

  reset_seq_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_n    (bus.btn_n),
    .btn_trig (btn_trig)
  );

`ifdef RESET_SEQUENCER_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Watchdog runs only while the system is up; a kick on the expiry cycle still saves it.
  always_comb begin
    wdog_trig = (state_q == ST_RUN) && (&wdog_q) && !bus.wdog_kick;
    wdog_d    = wdog_q + 1'b1;
    if (state_q != ST_RUN || bus.wdog_kick || wdog_trig) begin
      wdog_d = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic [WDOG_W-1:0] unused_wdog;
  assign unused_wdog = {WDOG_W{bus.wdog_kick}};
  assign wdog_trig   = 1'b0;
`endif

  assign trig = btn_trig | bus.ndmreset_req | wdog_trig;

  // Next state, hold/stagger count, cause and output levels; outputs derive from the next state
  // so the flops below present them glitch-free on the same edge as the state change.
  always_comb begin
    state_d = state_q;
    count_d = count_q + 1'b1;
    cause_d = cause_q;
    if (trig) begin
      state_d = ST_ASSERT;
      count_d = '0;
      if (btn_trig)       cause_d = CAUSE_BTN;
      else if (wdog_trig) cause_d = CAUSE_WDOG;
      else                cause_d = CAUSE_DBG;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (count_q == CNT_W'(HOLD_CYCLES - 1)) begin
            count_d = '0;
            if (STAGGER_CYCLES == 0) state_d = ST_RUN;
            else                     state_d = ST_RELEASE_PERIPH;
          end
        end
        ST_RELEASE_PERIPH: begin
          if (count_q == CNT_W'(STAGGER_CYCLES - 1)) begin
            count_d = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: count_d = count_q;
        default: begin
          state_d = ST_ASSERT;
          count_d = '0;
        end
      endcase
    end
    periph_d   = (state_d != ST_ASSERT);
    cpu_d      = (state_d == ST_RUN);
    in_reset_d = (state_d != ST_RUN);
  end

  // Sequencer FSM with registered reset outputs; cause survives everything but power-on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ASSERT;
      count_q    <= '0;
      periph_q   <= 1'b0;
      cpu_q      <= 1'b0;
      in_reset_q <= 1'b1;
      cause_q    <= CAUSE_POR;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      periph_q   <= periph_d;
      cpu_q      <= cpu_d;
      in_reset_q <= in_reset_d;
      cause_q    <= cause_d;
    end
  end

  assign bus.rst_n_periph = periph_q;
  assign bus.rst_n_cpu    = cpu_q;
  assign bus.in_reset     = in_reset_q;
  assign bus.reset_cause  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic kick_en;
  int   nvec = 0;
  int   nerr = 0;

  reset_sequencer_if bus_if ();

  reset_sequencer #(
    .DEBOUNCE_CYCLES (255),
    .HOLD_CYCLES     (16),
    .STAGGER_CYCLES  (8),
    .WDOG_W          (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Periodic watchdog service, one-cycle pulse roughly every 10 cycles while enabled.
  initial begin
    bus_if.wdog_kick = 1'b0;
    forever begin
      repeat (10) @(posedge clk);
      #2;
      if (kick_en) begin
        bus_if.wdog_kick = 1'b1;
        @(posedge clk);
        #2;
        bus_if.wdog_kick = 1'b0;
      end
    end
  end

  initial begin
    kick_en             = 1'b1;
    rst_n               = 1'b0;
    bus_if.btn_n        = 1'b1;
    bus_if.ndmreset_req = 1'b0;
    tick(3);
    chk("por_periph", 32'(bus_if.rst_n_periph), 0);
    chk("por_cpu",    32'(bus_if.rst_n_cpu),    0);
    chk("por_inrst",  32'(bus_if.in_reset),     1);
    chk("por_cause",  32'(bus_if.reset_cause),  0);

    // Power-on sequencing: periph at edge 16, cpu at edge 24.
    rst_n = 1'b1;
    tick(15);
    chk("seq_periph_e15", 32'(bus_if.rst_n_periph), 0);
    tick(1);
    chk("seq_periph_e16", 32'(bus_if.rst_n_periph), 1);
    chk("seq_cpu_e16",    32'(bus_if.rst_n_cpu),    0);
    tick(7);
    chk("seq_cpu_e23",    32'(bus_if.rst_n_cpu),    0);
    tick(1);
    chk("seq_cpu_e24",    32'(bus_if.rst_n_cpu),    1);
    chk("seq_inrst_e24",  32'(bus_if.in_reset),     0);
    chk("seq_cause",      32'(bus_if.reset_cause),  0);

    // Short button bounce is filtered out.
    bus_if.btn_n = 1'b0;
    tick(100);
    bus_if.btn_n = 1'b1;
    tick(50);
    chk("bounce_inrst", 32'(bus_if.in_reset), 0);

    // Long press: filter falls after 257 edges, resets one edge later.
    bus_if.btn_n = 1'b0;
    tick(257);
    chk("btn_periph_pre", 32'(bus_if.rst_n_periph), 1);
    tick(1);
    chk("btn_periph_low", 32'(bus_if.rst_n_periph), 0);
    chk("btn_cpu_low",    32'(bus_if.rst_n_cpu),    0);
    chk("btn_cause",      32'(bus_if.reset_cause),  1);
    tick(42);
    bus_if.btn_n = 1'b1;
    tick(272);
    chk("btn_rel_periph_pre", 32'(bus_if.rst_n_periph), 0);
    tick(1);
    chk("btn_rel_periph", 32'(bus_if.rst_n_periph), 1);
    chk("btn_rel_cpu_pre", 32'(bus_if.rst_n_cpu), 0);
    tick(8);
    chk("btn_rel_cpu",   32'(bus_if.rst_n_cpu),   1);
    chk("btn_rel_cause", 32'(bus_if.reset_cause), 1);

    // Debug request held 5 cycles.
    bus_if.ndmreset_req = 1'b1;
    tick(1);
    chk("dbg_periph_low", 32'(bus_if.rst_n_periph), 0);
    chk("dbg_cause",      32'(bus_if.reset_cause),  2);
    tick(4);
    bus_if.ndmreset_req = 1'b0;
    tick(15);
    chk("dbg_periph_pre", 32'(bus_if.rst_n_periph), 0);
    tick(1);
    chk("dbg_periph_rel", 32'(bus_if.rst_n_periph), 1);
    tick(8);
    chk("dbg_cpu_rel",    32'(bus_if.rst_n_cpu),    1);

    // Button and debug together: button wins.
    bus_if.btn_n = 1'b0;
    tick(257);
    bus_if.ndmreset_req = 1'b1;
    tick(1);
    chk("sim_inrst", 32'(bus_if.in_reset),    1);
    chk("sim_cause", 32'(bus_if.reset_cause), 1);
    bus_if.ndmreset_req = 1'b0;
    bus_if.btn_n        = 1'b1;
    tick(282);
    chk("sim_cpu_rel", 32'(bus_if.rst_n_cpu), 1);

    // Retrigger during stagger at count 4 restarts the full sequence.
    bus_if.ndmreset_req = 1'b1;
    tick(1);
    bus_if.ndmreset_req = 1'b0;
    tick(16);
    chk("rt_periph_up", 32'(bus_if.rst_n_periph), 1);
    chk("rt_cpu_down",  32'(bus_if.rst_n_cpu),    0);
    tick(4);
    bus_if.ndmreset_req = 1'b1;
    tick(1);
    bus_if.ndmreset_req = 1'b0;
    chk("rt_periph_drop", 32'(bus_if.rst_n_periph), 0);
    tick(15);
    chk("rt_periph_pre",  32'(bus_if.rst_n_periph), 0);
    tick(1);
    chk("rt_periph_rel",  32'(bus_if.rst_n_periph), 1);
    tick(7);
    chk("rt_cpu_pre",     32'(bus_if.rst_n_cpu),    0);
    tick(1);
    chk("rt_cpu_rel",     32'(bus_if.rst_n_cpu),    1);
    chk("rt_cause",       32'(bus_if.reset_cause),  2);

`ifdef RESET_SEQUENCER_WDOG_EN
    // Watchdog starved: expires after 16 RUN cycles.
    kick_en = 1'b0;
    bus_if.ndmreset_req = 1'b1;
    tick(1);
    bus_if.ndmreset_req = 1'b0;
    tick(24);
    chk("wd_cpu_rel", 32'(bus_if.rst_n_cpu), 1);
    tick(15);
    chk("wd_inrst_pre", 32'(bus_if.in_reset), 0);
    tick(1);
    chk("wd_periph_low", 32'(bus_if.rst_n_periph), 0);
    chk("wd_cause",      32'(bus_if.reset_cause),  3);
    kick_en = 1'b1;
    tick(24);
    chk("wd_cpu_rel2", 32'(bus_if.rst_n_cpu), 1);
    tick(200);
    chk("wd_kicked_inrst", 32'(bus_if.in_reset),    0);
    chk("wd_kicked_cause", 32'(bus_if.reset_cause), 3);
`else
    // Without the watchdog, a long run with or without kicks never resets.
    kick_en = 1'b0;
    tick(200);
    chk("nowd_inrst", 32'(bus_if.in_reset),    0);
    chk("nowd_cause", 32'(bus_if.reset_cause), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
